// File: rtl/led_shift_sequencer.sv
// LED shift-register controller: manual left/right shifts, mode cycling and
// prescaled auto patterns (running light left/right, ping-pong).
module led_shift_sequencer #(
   parameter int TICK_DIV = 12500000,
   parameter int CNT_W    = 24
) (
   input  logic       clk,
   input  logic       rst_key,
   input  logic       mode_key,
   input  logic       ls_key,
   input  logic       rs_key,
   input  logic       ls_bit,
   input  logic       rs_bit,
   output logic [7:0] LEDS,
   output logic [1:0] mode
);

   localparam logic [1:0] MANUAL   = 2'd0;
   localparam logic [1:0] AUTO_L   = 2'd1;
   localparam logic [1:0] AUTO_R   = 2'd2;
   localparam logic [1:0] PINGPONG = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Key order in the vectors below: bit0 mode, bit1 left shift, bit2 right shift.
   logic [2:0] key_in;
   logic [2:0] k_r;
   logic [2:0] k_rr;
   logic [2:0] armed;
   logic [2:0] press;

   logic [CNT_W-1:0] cnt;
   logic             dir_left;
   logic             tick;
   logic [7:0]       auto_leds;
   logic             auto_dir;

   assign key_in = {rs_key, ls_key, mode_key};

   // A key must be seen released after reset before its falling edge counts,
   // so a button held through reset does not fire on release of reset.
   always_ff @(posedge clk) begin
      if (!rst_key) begin
         k_r   <= 3'b111;
         k_rr  <= 3'b111;
         armed <= 3'b000;
      end else begin
         k_r   <= key_in;
         k_rr  <= k_r;
         armed <= armed | key_in;
      end
   end

   assign press = k_rr & ~k_r & armed;
   assign tick  = (mode != MANUAL) && (cnt == CNT_LAST);

   // An empty register is seeded instead of rotated so auto modes always show a light.
   always_comb begin
      auto_leds = LEDS;
      auto_dir  = dir_left;
      if (LEDS == 8'h00) begin
         auto_leds = 8'h01;
      end else begin
         case (mode)
            AUTO_L:   auto_leds = {LEDS[6:0], LEDS[7]};
            AUTO_R:   auto_leds = {LEDS[0], LEDS[7:1]};
            PINGPONG: begin
               auto_leds = dir_left ? {LEDS[6:0], LEDS[7]} : {LEDS[0], LEDS[7:1]};
               if (dir_left && auto_leds[7]) begin
                  auto_dir = 1'b0;
               end else if (!dir_left && auto_leds[0]) begin
                  auto_dir = 1'b1;
               end
            end
            default: auto_leds = LEDS;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_key) begin
         LEDS     <= 8'h00;
         mode     <= MANUAL;
         dir_left <= 1'b1;
         cnt      <= '0;
      end else if (press[0]) begin
         mode <= mode + 2'd1;
         cnt  <= '0;
         if (mode == AUTO_R) begin
            dir_left <= 1'b1;
         end
      end else begin
         if (mode == MANUAL || tick) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
         // A tick that collides with a manual press is simply lost.
         if (press[1]) begin
            LEDS <= {LEDS[6:0], ls_bit};
         end else if (press[2]) begin
            LEDS <= {rs_bit, LEDS[7:1]};
         end else if (tick) begin
            LEDS     <= auto_leds;
            dir_left <= auto_dir;
         end
      end
   end

endmodule

// File: doc/led_shift_sequencer.md
Name: led_shift_sequencer

Overview:
- Controller that owns the 8-bit LED shift register and decides, every cycle, which operation it performs.
- Operations come from three sources: manual left/right shift buttons, a mode button, and an internal prescaled auto-tick.
- Auto modes: running light left, running light right, ping-pong.
- Sits between the board push-buttons and the LED bank. It replaces direct button-to-register wiring at top level.

Parameters:
- TICK_DIV, 12500000, clk cycles per auto-shift step (>=2); tests use 4.
- CNT_W, 24, prescaler counter width; must hold TICK_DIV-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_key  input  1  synchronous reset, active-low, sampled directly (not via edge detector).
- mode_key  input  1  mode-cycle button, active-low (pressed = 0).
- ls_key  input  1  manual left-shift button, active-low.
- rs_key  input  1  manual right-shift button, active-low.
- ls_bit  input  1  bit inserted at LSB on a manual left shift.
- rs_bit  input  1  bit inserted at MSB on a manual right shift.
- LEDS  output  8  current register contents.
- mode  output  2  0=MANUAL, 1=AUTO_L, 2=AUTO_R, 3=PINGPONG.

Behaviour:
- Reset (rst_key=0 at a posedge):
  - LEDS=0, mode=MANUAL, pingpong dir=LEFT, prescaler=0.
  - All key sync flops (2 per key) load 1.
  - Reset overrides every other event in that cycle.
- Key detection, per key:
  - Two flops in series, k_r then k_rr.
  - press = k_rr & ~k_r, a one-cycle pulse on the 1->0 transition.
  - Key low before edge N gives a pulse between edges N and N+1; the action is applied at edge N+1.
  - Holding a key gives exactly one pulse. No debounce is done in this block.
- Mode FSM, advanced by the mode press:
  - Sequence: MANUAL -> AUTO_L -> AUTO_R -> PINGPONG -> MANUAL.
  - On any mode change the prescaler clears to 0. In PINGPONG, dir is set to LEFT on entry.
  - LEDS is not altered by a mode change.
- Prescaler:
  - Counts only when mode != MANUAL, otherwise holds 0.
  - tick = (cnt == TICK_DIV-1); when tick is high, cnt returns to 0 at that edge.
  - The first auto step therefore lands TICK_DIV cycles after mode entry.
- Register update priority (highest first, one action per cycle):
  1. mode press: no shift.
  2. ls press: LEDS <= {LEDS[6:0], ls_bit}.
  3. rs press: LEDS <= {rs_bit, LEDS[7:1]}.
  4. tick:
     - AUTO_L: rotate left, {LEDS[6:0], LEDS[7]}.
     - AUTO_R: rotate right, {LEDS[0], LEDS[7:1]}.
     - PINGPONG: rotate in direction dir. After the rotate, if new LEDS[7]=1 and dir=LEFT, dir <= RIGHT. If new LEDS[0]=1 and dir=RIGHT, dir <= LEFT.
- Manual presses are honoured in every mode. A tick coinciding with any press is dropped, not deferred, and the prescaler keeps counting.
- Seed rule: a tick while LEDS==0 in any auto mode loads 8'h01 instead of rotating. This counts as the step, and no dir update is made.
- Simultaneous ls and rs presses: left wins and rs is discarded.
- Reset mid-operation (during a held key or mid-count): everything returns to reset values. A key still held low at reset release produces no press until it is released and pressed again.
- mode output is the registered FSM state. LEDS is the register, zero combinational paths to the outputs.

Test Plan:
- Reset, then hold ls_bit=1 and press ls_key three times (separated) -> LEDS=8'h07. Then rs_bit=0 with one rs press -> LEDS=8'h03. mode stays 0 throughout.
- Press mode once (TICK_DIV=4), LEDS=0 -> mode=1. First tick 4 cycles later gives LEDS=8'h01. Subsequent ticks every 4 cycles give 02, 04, ... 80, then 01 (wrap).
- mode=2 with LEDS=8'h01 -> ticks give 80, 40, 20. Pressing mode during the count gives mode=3, prescaler restarts, and LEDS is unchanged at the press.
- PINGPONG from LEDS=8'h40, dir LEFT -> steps 80 (dir->RIGHT), 40, 20, 10, 08, 04, 02, 01 (dir->LEFT), then 02.
- In AUTO_L, ls press in the same cycle as a tick, ls_bit=0, LEDS=8'h11 -> LEDS=8'h22 from the shift only; the tick is lost and the next tick comes TICK_DIV cycles later. ls and rs pressed together -> only the left shift occurs.
- rst_key=0 for one cycle mid-count in PINGPONG with ls_key held low -> LEDS=0, mode=0. Releasing ls_key gives no shift; a new press gives one shift.
